// File: rtl/cp_fifo_fetch.sv
// Command FIFO fetch engine: AXI4 read master that walks the CP ring buffer in
// 32-byte lines and hands the beats to the CP parser through a FWFT line buffer.
module cp_fifo_fetch #(
  parameter int BUF_DEPTH = 8,
  parameter int BURST_LEN = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [31:0]  fifo_base,
  input  logic [31:0]  fifo_end,
  input  logic [31:0]  fifo_wrptr,
  input  logic         rdptr_load,
  input  logic [31:0]  rdptr_load_value,
  output logic [31:0]  fifo_rdptr,
  output logic         busy,
  output logic         error,
  input  logic         error_clear,
  output logic [31:0]  araddrm_a,
  output logic [1:0]   arburstm_a,
  output logic [3:0]   arlenm_a,
  output logic [2:0]   arsizem_a,
  output logic         arvalidm_a,
  input  logic         arreadym_a,
  input  logic [127:0] rdatam_a,
  input  logic [1:0]   rrespm_a,
  input  logic         rlastm_a,
  input  logic         rvalidm_a,
  output logic         rreadym_a,
  output logic [127:0] cmd_data,
  output logic         cmd_valid,
  input  logic         cmd_ready
);
  // state  | meaning
  // S_IDLE | no burst outstanding; accepts rdptr_load, decides next fetch
  // S_ADDR | arvalid held with a stable address until arready
  // S_DATA | rready held; beats pushed into the buffer until rlast

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0] C_BURST = (AW+1)'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_araddr, w_araddr_nxt;
  logic [31:0]   r_rdptr, w_rdptr_nxt;
  logic          r_arvalid, w_arvalid_nxt;
  logic          r_rready, w_rready_nxt;
  logic          r_error;
  logic          w_flush;

  logic [127:0]  r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_idx, r_rd_idx;
  logic [AW:0]   r_count;
  logic [AW:0]   w_free;
  logic          w_pending, w_beat, w_push, w_pop, w_err_beat;
  logic          w_unused;

  assign w_unused   = ^{fifo_base[4:0], fifo_end[4:0], fifo_wrptr[4:0], rdptr_load_value[4:0]};

  assign w_pending  = (r_rdptr[31:5] != fifo_wrptr[31:5]);
  assign w_free     = C_DEPTH - r_count;
  assign w_beat     = (r_state == S_DATA) && rvalidm_a && r_rready;
  assign w_push     = w_beat && (rrespm_a == 2'b00);
  assign w_err_beat = w_beat && (rrespm_a != 2'b00);
  assign w_pop      = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_araddr  <= '0;
      r_rdptr   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_araddr  <= w_araddr_nxt;
      r_rdptr   <= w_rdptr_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_araddr_nxt  = r_araddr;
    w_rdptr_nxt   = r_rdptr;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_flush       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rdptr_load) begin
          w_rdptr_nxt = {rdptr_load_value[31:5], 5'b0};
          w_flush     = 1'b1;
        end else if (enable && w_pending && (w_free >= C_BURST)) begin
          w_araddr_nxt  = r_rdptr;
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arreadym_a) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalidm_a && rlastm_a) begin
          w_rready_nxt = 1'b0;
          // ring wraps only when the line just fetched was the last one
          if (r_rdptr[31:5] == fifo_end[31:5]) w_rdptr_nxt = {fifo_base[31:5], 5'b0};
          else                                 w_rdptr_nxt = r_rdptr + 32'd32;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_idx] <= rdatam_a;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          r_error <= 1'b0;
    else if (w_err_beat)  r_error <= 1'b1;
    else if (error_clear) r_error <= 1'b0;
  end

  assign cmd_valid  = (r_count != '0);
  assign cmd_data   = cmd_valid ? r_mem[r_rd_idx] : '0;

  assign fifo_rdptr = r_rdptr;
  assign busy       = (r_state != S_IDLE);
  assign error      = r_error;
  assign araddrm_a  = r_araddr;
  assign arvalidm_a = r_arvalid;
  assign rreadym_a  = r_rready;
  assign arburstm_a = 2'b01;
  assign arlenm_a   = 4'(BURST_LEN - 1);
  assign arsizem_a  = 3'b100;
endmodule

// File: tb/tb_cp_fifo_fetch.sv
// Bench for cp_fifo_fetch: AXI slave responder, random-ready consumer and a
// line-level ring/queue model that predicts fetch addresses and command data.
module tb_cp_fifo_fetch;
  logic         clk = 1'b0;
  logic         resetn, enable, rdptr_load, error_clear;
  logic [31:0]  fifo_base, fifo_end, fifo_wrptr, rdptr_load_value, fifo_rdptr;
  logic         busy, error;
  logic [31:0]  araddrm_a;
  logic [1:0]   arburstm_a;
  logic [3:0]   arlenm_a;
  logic [2:0]   arsizem_a;
  logic         arvalidm_a, arreadym_a;
  logic [127:0] rdatam_a;
  logic [1:0]   rrespm_a;
  logic         rlastm_a, rvalidm_a, rreadym_a;
  logic [127:0] cmd_data;
  logic         cmd_valid, cmd_ready;

  cp_fifo_fetch #(.BUF_DEPTH(8), .BURST_LEN(2)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo_base(fifo_base), .fifo_end(fifo_end), .fifo_wrptr(fifo_wrptr),
    .rdptr_load(rdptr_load), .rdptr_load_value(rdptr_load_value),
    .fifo_rdptr(fifo_rdptr), .busy(busy), .error(error), .error_clear(error_clear),
    .araddrm_a(araddrm_a), .arburstm_a(arburstm_a), .arlenm_a(arlenm_a),
    .arsizem_a(arsizem_a), .arvalidm_a(arvalidm_a), .arreadym_a(arreadym_a),
    .rdatam_a(rdatam_a), .rrespm_a(rrespm_a), .rlastm_a(rlastm_a),
    .rvalidm_a(rvalidm_a), .rreadym_a(rreadym_a),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: next line the ring should be read from, and expected beats
  logic [31:0]  model_ptr = '0;
  logic [127:0] exp_q[$];
  logic [31:0]  addr_log[$];
  int           burst_cnt = 0;
  int           hold_at   = -1;
  bit           r_abort   = 0;
  int           ar_stall  = 0;
  bit           gap_en    = 0;
  bit           err_next  = 0;
  bit           ready_mode = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI read slave
  initial begin : axi_slave
    logic [31:0]  sl_addr;
    logic [127:0] beat;
    arreadym_a = 1'b0; rvalidm_a = 1'b0; rdatam_a = '0; rrespm_a = 2'b00; rlastm_a = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && arvalidm_a) begin
        sl_addr = araddrm_a;
        chk("araddr", sl_addr, model_ptr);
        addr_log.push_back(sl_addr);
        for (int i = 0; i < ar_stall; i++) begin
          @(negedge clk);
          chk("araddr_stable", {arvalidm_a, araddrm_a}, {1'b1, sl_addr});
        end
        arreadym_a = 1'b1;
        @(negedge clk);
        arreadym_a = 1'b0;
        burst_cnt++;
        chk("rready_in_data", rreadym_a, 1'b1);
        while (burst_cnt == hold_at) @(negedge clk);
        if (r_abort) begin
          r_abort = 0;
        end else begin
          for (int b = 0; b < 2; b++) begin
            if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk);
            beat = {sl_addr, 32'(b), $urandom, $urandom};
            rvalidm_a = 1'b1;
            rdatam_a  = beat;
            rrespm_a  = (b == 0 && err_next) ? 2'b10 : 2'b00;
            rlastm_a  = (b == 1);
            if (rrespm_a == 2'b00) exp_q.push_back(beat);
            @(negedge clk);
            rvalidm_a = 1'b0; rlastm_a = 1'b0; rrespm_a = 2'b00;
          end
          err_next = 0;
          if (model_ptr[31:5] == fifo_end[31:5]) model_ptr = {fifo_base[31:5], 5'b0};
          else                                   model_ptr = model_ptr + 32'd32;
        end
      end
    end
  end

  // command consumer
  initial begin : consumer
    cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      cmd_ready = (ready_mode && resetn) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (cmd_valid && cmd_ready) begin
        chk("cmd_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("cmd_data", cmd_data, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_ptr(input logic [31:0] v);
    rdptr_load_value = v;
    rdptr_load = 1'b1;
    @(negedge clk);
    rdptr_load = 1'b0;
    model_ptr = {v[31:5], 5'b0};
    exp_q.delete();
    addr_log.delete();
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!(model_ptr[31:5] == fifo_wrptr[31:5] && !busy && exp_q.size() == 0 && !cmd_valid)
           && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", n < max, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] ld, input logic [31:0] wr, input int max);
    enable = 1'b0;
    load_ptr(ld);
    fifo_wrptr = wr;
    enable = 1'b1;
    wait_done(max);
  endtask

  initial begin : main
    int b0;
    int n;
    resetn = 1'b0; enable = 1'b0; rdptr_load = 1'b0; rdptr_load_value = '0; error_clear = 1'b0;
    fifo_base = 32'h1000; fifo_end = 32'h1FE0; fifo_wrptr = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {arvalidm_a, rreadym_a, busy, error, cmd_valid}, 5'b0);
    chk("rst_araddr", araddrm_a, 32'h0);
    chk("rst_rdptr", fifo_rdptr, 32'h0);
    chk("rst_cmd_data", cmd_data, 128'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ar_const", {arburstm_a, arlenm_a, arsizem_a}, {2'b01, 4'd1, 3'b100});

    // basic fetch
    ready_mode = 1;
    b0 = burst_cnt;
    fetch(32'h1000, 32'h1040, 300);
    chk("basic_rdptr", fifo_rdptr, 32'h1040);
    repeat (20) @(negedge clk);
    chk("basic_bursts", burst_cnt - b0, 2);
    chk("basic_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hx, 32'h1000);
    chk("basic_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hx, 32'h1020);

    // ring wrap
    b0 = burst_cnt;
    fetch(32'h1FE0, 32'h1020, 300);
    chk("wrap_rdptr", fifo_rdptr, 32'h1020);
    chk("wrap_bursts", burst_cnt - b0, 2);
    chk("wrap_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hx, 32'h1FE0);
    chk("wrap_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hx, 32'h1000);

    // backpressure: 10 lines pending, consumer stalled
    ready_mode = 0;
    enable = 1'b0;
    load_ptr(32'h1000);
    fifo_wrptr = 32'h1140;
    b0 = burst_cnt;
    enable = 1'b1;
    repeat (150) @(negedge clk);
    chk("bp_bursts", burst_cnt - b0, 4);
    chk("bp_idle", {arvalidm_a, busy, cmd_valid}, 3'b001);
    ready_mode = 1;
    wait_done(2000);
    chk("bp_total_bursts", burst_cnt - b0, 10);
    chk("bp_rdptr", fifo_rdptr, 32'h1140);

    // AXI stalls and gapped rvalid
    ar_stall = 5;
    gap_en = 1;
    fetch(32'h1200, 32'h1280, 1000);
    chk("stall_rdptr", fifo_rdptr, 32'h1280);
    ar_stall = 0;
    gap_en = 0;

    // error response on beat 0
    err_next = 1;
    fetch(32'h1300, 32'h1320, 300);
    chk("err_set", error, 1'b1);
    chk("err_rdptr", fifo_rdptr, 32'h1320);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    chk("err_cleared", error, 1'b0);

    // rdptr_load while busy is ignored
    ar_stall = 5;
    enable = 1'b0;
    load_ptr(32'h1400);
    fifo_wrptr = 32'h1440;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk("busy_seen", busy, 1'b1);
    rdptr_load_value = 32'h1800;
    rdptr_load = 1'b1;
    @(negedge clk);
    rdptr_load = 1'b0;
    chk("load_busy_ignored", fifo_rdptr, 32'h1400);
    wait_done(500);
    chk("load_busy_rdptr", fifo_rdptr, 32'h1440);
    ar_stall = 0;

    // reset in the middle of a data phase
    ready_mode = 0;
    enable = 1'b0;
    load_ptr(32'h1500);
    fifo_wrptr = 32'h1540;
    b0 = burst_cnt;
    hold_at = b0 + 2;
    enable = 1'b1;
    n = 0;
    while (!(burst_cnt == b0 + 2 && rreadym_a) && n < 100) begin @(negedge clk); n++; end
    chk("pre_rst", {busy, cmd_valid, rreadym_a}, 3'b111);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ctrl", {arvalidm_a, rreadym_a, busy, error, cmd_valid}, 5'b0);
    chk("mid_rst_araddr", araddrm_a, 32'h0);
    chk("mid_rst_rdptr", fifo_rdptr, 32'h0);
    chk("mid_rst_cmd_data", cmd_data, 128'h0);
    r_abort = 1;
    hold_at = -1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy, arvalidm_a}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
